// File: rtl/alu_multicycle_pkg.sv
// -----------------------------------------------------------------------------
// alu_multicycle_pkg
// Shared definitions for the execution-stage ALU. The ALU control decoder
// uses the same 4-bit op codes, so they live here rather than in the ALU.
//   - OP_* : ALUOperation encodings (anything not listed produces 0)
//   - ST_* : state encodings of the ALU's start/busy/done FSM
// -----------------------------------------------------------------------------
package alu_multicycle_pkg;

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_NOR = 4'b0010;
  localparam logic [3:0] OP_ADD = 4'b0011;
  localparam logic [3:0] OP_SUB = 4'b0100;
  localparam logic [3:0] OP_MUL = 4'b0101;
  localparam logic [3:0] OP_NOP = 4'b1001;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_MUL  = 1'b1;

endpackage : alu_multicycle_pkg

// File: rtl/alu_multicycle_mul_shift_add.sv
// -----------------------------------------------------------------------------
// alu_multicycle_mul_shift_add
// Iterative unsigned shift-add multiplier: one partial product per clock,
// NBITS clocks per multiplication.
//   clk     : system clock, rising edge
//   reset   : asynchronous, active-low
//   load    : capture A/B, clear accumulator and counter, start iterating
//   A, B    : multiplicand / multiplier (sampled only when load=1)
//   product : accumulator value being written at this edge (includes the
//             current partial product), so it is the full product when last=1
//   last    : this edge performs the final (NBITS-th) iteration
// -----------------------------------------------------------------------------
module alu_multicycle_mul_shift_add #(
  parameter int NBITS = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load,
  input  logic [NBITS-1:0]   A,
  input  logic [NBITS-1:0]   B,
  output logic [2*NBITS-1:0] product,
  output logic               last
);

  localparam int CNT_W = $clog2(NBITS) + 1;

  logic [2*NBITS-1:0] r_acc;
  logic [2*NBITS-1:0] r_mcand;
  logic [NBITS-1:0]   r_mplier;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_active;

  logic [2*NBITS-1:0] w_addend;
  logic [2*NBITS-1:0] w_acc_next;

  assign w_addend   = r_mplier[0] ? r_mcand : '0;
  assign w_acc_next = r_acc + w_addend;
  assign product    = w_acc_next;
  assign last       = r_active && (r_cnt == CNT_W'(NBITS - 1));

  // NOTE: state registers use non-blocking assignments so every register in
  // this block samples pre-edge values, matching the hardware they describe.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_acc    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_cnt    <= '0;
      r_active <= 1'b0;
    end else if (load) begin
      r_acc    <= '0;
      r_mcand  <= {{NBITS{1'b0}}, A};
      r_mplier <= B;
      r_cnt    <= '0;
      r_active <= 1'b1;
    end else if (r_active) begin
      r_acc    <= w_acc_next;
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
      r_cnt    <= r_cnt + 1'b1;
      if (last) r_active <= 1'b0;
    end
  end

endmodule : alu_multicycle_mul_shift_add

// File: rtl/alu_multicycle.sv
// -----------------------------------------------------------------------------
// alu_multicycle
// Execution-stage ALU with a start/busy/done handshake. AND/OR/NOR/ADD/SUB
// (and undefined codes, which yield 0) complete in one cycle; unsigned MUL
// iterates for NBITS cycles and returns a 2*NBITS product.
//   clk          : system clock, rising edge
//   reset        : asynchronous, active-low; clears all state
//   start        : request, accepted only when idle
//   ALUOperation : 4-bit op code from ALU control
//   A, B         : operands
//   ALUResult    : result (low product half for MUL)
//   ResultHi     : high product half for MUL, 0 otherwise
//   Zero         : ALUResult == 0, registered with ALUResult
//   busy         : high while a MUL iterates
//   done         : one-cycle pulse when the outputs have been updated
// -----------------------------------------------------------------------------
module alu_multicycle
  import alu_multicycle_pkg::*;
#(
  parameter int NBITS = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       ALUOperation,
  input  logic [NBITS-1:0] A,
  input  logic [NBITS-1:0] B,
  output logic [NBITS-1:0] ALUResult,
  output logic [NBITS-1:0] ResultHi,
  output logic             Zero,
  output logic             busy,
  output logic             done
);

  logic [0:0]       r_state;
  logic [NBITS-1:0] r_result;
  logic [NBITS-1:0] r_result_hi;
  logic             r_zero;
  logic             r_busy;
  logic             r_done;

  logic             w_accept;
  logic             w_mul_load;
  logic [NBITS-1:0] w_single;
  logic [2*NBITS-1:0] w_product;
  logic             w_mul_last;

  assign w_accept   = (r_state == ST_IDLE) && start;
  assign w_mul_load = w_accept && (ALUOperation == OP_MUL);

  // NOTE: the default assignment ahead of the case keeps this block purely
  // combinational for every op code, so no latch is inferred.
  always_comb begin
    w_single = '0;
    case (ALUOperation)
      OP_AND:  w_single = A & B;
      OP_OR:   w_single = A | B;
      OP_NOR:  w_single = ~(A | B);
      OP_ADD:  w_single = A + B;
      OP_SUB:  w_single = A - B;
      default: w_single = '0;
    endcase
  end

  alu_multicycle_mul_shift_add #(.NBITS(NBITS)) u_mul (
    .clk     (clk),
    .reset   (reset),
    .load    (w_mul_load),
    .A       (A),
    .B       (B),
    .product (w_product),
    .last    (w_mul_last)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= ST_IDLE;
      r_result    <= '0;
      r_result_hi <= '0;
      r_zero      <= 1'b1;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            if (ALUOperation == OP_MUL) begin
              // Outputs keep their previous values while the multiply runs.
              r_state <= ST_MUL;
              r_busy  <= 1'b1;
            end else begin
              r_result    <= w_single;
              r_result_hi <= '0;
              r_zero      <= (w_single == '0);
              r_done      <= 1'b1;
            end
          end
        end
        ST_MUL: begin
          // start is deliberately ignored here; requests are not queued.
          if (w_mul_last) begin
            r_result    <= w_product[NBITS-1:0];
            r_result_hi <= w_product[2*NBITS-1:NBITS];
            r_zero      <= (w_product[NBITS-1:0] == '0);
            r_state     <= ST_IDLE;
            r_busy      <= 1'b0;
            r_done      <= 1'b1;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign ALUResult = r_result;
  assign ResultHi  = r_result_hi;
  assign Zero      = r_zero;
  assign busy      = r_busy;
  assign done      = r_done;

endmodule : alu_multicycle

// File: tb/tb_alu_multicycle.sv
// -----------------------------------------------------------------------------
// tb_alu_multicycle
// Directed bench for alu_multicycle (NBITS=32). Inputs change and outputs are
// sampled on the falling edge, away from the active rising edge.
// -----------------------------------------------------------------------------
module tb_alu_multicycle;

  localparam int NBITS = 32;

  logic             clk;
  logic             reset;
  logic             start;
  logic [3:0]       ALUOperation;
  logic [NBITS-1:0] A;
  logic [NBITS-1:0] B;
  logic [NBITS-1:0] ALUResult;
  logic [NBITS-1:0] ResultHi;
  logic             Zero;
  logic             busy;
  logic             done;

  int total = 0;
  int bad   = 0;

  alu_multicycle #(.NBITS(NBITS)) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .ALUOperation (ALUOperation),
    .A            (A),
    .B            (B),
    .ALUResult    (ALUResult),
    .ResultHi     (ResultHi),
    .Zero         (Zero),
    .busy         (busy),
    .done         (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, ".result"}, 64'(ALUResult), 64'h0);
    check({tag, ".hi"},     64'(ResultHi),  64'h0);
    check({tag, ".zero"},   64'(Zero),      64'h1);
    check({tag, ".busy"},   64'(busy),      64'h0);
    check({tag, ".done"},   64'(done),      64'h0);
  endtask

  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    start        = 1'b1;
    ALUOperation = op;
    A            = a;
    B            = b;
  endtask

  int busy_cycles;
  int done_seen;
  int wait_cnt;

  initial begin
    reset        = 1'b0;
    start        = 1'b0;
    ALUOperation = 4'b0000;
    A            = '0;
    B            = '0;

    // Reset for two cycles, then idle with start low.
    repeat (2) @(negedge clk);
    check_reset_vals("reset");
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_vals("idle");

    // ADD wraps to zero.
    issue(4'b0011, 32'hFFFF_FFFF, 32'h1);
    @(negedge clk);
    start = 1'b0;
    check("add.done",   64'(done),      64'h1);
    check("add.result", 64'(ALUResult), 64'h0);
    check("add.zero",   64'(Zero),      64'h1);
    check("add.busy",   64'(busy),      64'h0);
    @(negedge clk);
    check("add.done_fall", 64'(done), 64'h0);
    check("add.busy2",     64'(busy), 64'h0);

    // SUB, then NOR issued in SUB's done cycle.
    issue(4'b0100, 32'd10, 32'd3);
    @(negedge clk);
    check("sub.done",   64'(done),      64'h1);
    check("sub.result", 64'(ALUResult), 64'd7);
    check("sub.zero",   64'(Zero),      64'h0);
    issue(4'b0010, 32'h0, 32'h0000_FFFF);
    @(negedge clk);
    start = 1'b0;
    check("nor.done",   64'(done),      64'h1);
    check("nor.result", 64'(ALUResult), 64'hFFFF_0000);
    check("nor.hi",     64'(ResultHi),  64'h0);
    @(negedge clk);
    check("nor.done_fall", 64'(done), 64'h0);

    // MUL 0xFFFFFFFF * 2; start pulses during busy must be ignored.
    issue(4'b0101, 32'hFFFF_FFFF, 32'h2);
    busy_cycles = 0;
    done_seen   = 0;
    for (int i = 1; i <= 32; i++) begin
      @(negedge clk);
      start = 1'b0;
      if (busy) busy_cycles++;
      if (done) done_seen++;
      if (i == 5 || i == 6) issue(4'b0011, 32'd1, 32'd1);
      if (i == 16) begin
        check("mul.hold_result", 64'(ALUResult), 64'hFFFF_0000);
        check("mul.hold_zero",   64'(Zero),      64'h0);
      end
    end
    check("mul.busy_cycles", 64'(busy_cycles), 64'd32);
    check("mul.no_early_done", 64'(done_seen), 64'd0);
    @(negedge clk);
    check("mul.done",   64'(done),      64'h1);
    check("mul.busy",   64'(busy),      64'h0);
    check("mul.hi",     64'(ResultHi),  64'h1);
    check("mul.result", 64'(ALUResult), 64'hFFFF_FFFE);
    check("mul.zero",   64'(Zero),      64'h0);
    @(negedge clk);
    check("mul.done_fall", 64'(done),      64'h0);
    check("mul.held",      64'(ALUResult), 64'hFFFF_FFFE);

    // Undefined op code 1001.
    issue(4'b1001, 32'd5, 32'd5);
    @(negedge clk);
    start = 1'b0;
    check("nop.done",   64'(done),      64'h1);
    check("nop.result", 64'(ALUResult), 64'h0);
    check("nop.hi",     64'(ResultHi),  64'h0);
    check("nop.zero",   64'(Zero),      64'h1);
    @(negedge clk);

    // Make outputs non-reset, then abort a MUL 7*9 with reset at iteration 10.
    issue(4'b0011, 32'd3, 32'd4);
    @(negedge clk);
    start = 1'b0;
    check("add2.result", 64'(ALUResult), 64'd7);
    @(negedge clk);
    issue(4'b0101, 32'd7, 32'd9);
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      start = 1'b0;
    end
    check("abort.busy_before", 64'(busy), 64'h1);
    reset = 1'b0;
    #1;
    check_reset_vals("abort");
    @(negedge clk);
    reset = 1'b1;
    done_seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done || busy) done_seen++;
    end
    check("abort.no_done", 64'(done_seen), 64'd0);
    check_reset_vals("abort.after");

    // Recovery: a fresh MUL 7*9 completes normally.
    issue(4'b0101, 32'd7, 32'd9);
    @(negedge clk);
    start = 1'b0;
    wait_cnt = 0;
    while (!done && wait_cnt < 40) begin
      @(negedge clk);
      wait_cnt++;
    end
    check("mul2.latency", 64'(wait_cnt), 64'd32);
    check("mul2.result",  64'(ALUResult), 64'd63);
    check("mul2.hi",      64'(ResultHi),  64'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_alu_multicycle
